// File: rtl/window_serializer.sv
// window_serializer: takes one byte at a time through a valid/ready holding
// register and shifts it out MSB-first while the upstream enable window is
// high. The window length is checked (underrun / short / long) and every
// correctly sized frame is counted.
//
// Handshake: a byte is taken on any rising clk edge where din_valid and
// din_ready are both 1. din_ready is simply "holding register empty". The
// producer keeps din stable while din_valid is high and ready is low.
module window_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             err_underrun,
    output logic             err_short,
    output logic             err_long,
    output logic [CNT_W-1:0] frame_count
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0] FULL_CNT = BC_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic             sout_d, sout_valid_d, done_d;
    logic             under_d, short_d, long_d;
    logic [CNT_W-1:0] count_d;

    // The only combinational output: ready whenever the holding register is free.
    assign din_ready = ~hold_full_q;

    // Next-state, datapath and registered-output decode for the frame FSM.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        done_d       = 1'b0;
        under_d      = 1'b0;
        short_d      = 1'b0;
        long_d       = 1'b0;
        count_d      = frame_count;

        case (state_q)
            IDLE: begin
                if (en) begin
                    if (hold_full_q) begin
                        // First bit leaves on the same edge the window is seen.
                        shift_d      = hold_q << 1;
                        sout_d       = hold_q[WIDTH-1];
                        sout_valid_d = 1'b1;
                        bitcnt_d     = BC_W'(1);
                        hold_full_d  = 1'b0;
                        state_d      = SHIFT;
                    end else begin
                        under_d = 1'b1;
                        state_d = WAIT_LOW;
                    end
                end
            end
            SHIFT: begin
                if (en) begin
                    if (bitcnt_q < FULL_CNT) begin
                        sout_d       = shift_q[WIDTH-1];
                        shift_d      = shift_q << 1;
                        bitcnt_d     = bitcnt_q + 1'b1;
                        sout_valid_d = 1'b1;
                    end else begin
                        long_d  = 1'b1;
                        state_d = WAIT_LOW;
                    end
                end else begin
                    if (bitcnt_q == FULL_CNT) begin
                        done_d  = 1'b1;
                        count_d = frame_count + 1'b1;
                    end else begin
                        short_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept a new byte only into an empty holder; when the holder is
        // being emptied on this same edge it was not empty, so no conflict.
        if (din_valid && !hold_full_q) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end
    end

    // State and output registers; reset drops everything, including held data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            sout         <= 1'b0;
            sout_valid   <= 1'b0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            frame_count  <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            sout         <= sout_d;
            sout_valid   <= sout_valid_d;
            done         <= done_d;
            err_underrun <= under_d;
            err_short    <= short_d;
            err_long     <= long_d;
            frame_count  <= count_d;
        end
    end

endmodule

// File: tb/tb_window_serializer.sv
// Bench for window_serializer: directed scenarios plus random windows, all
// outputs compared every cycle against a window-position reference model.
module tb_window_serializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             done;
    logic             err_underrun;
    logic             err_short;
    logic             err_long;
    logic [CNT_W-1:0] frame_count;

    int checks = 0;
    int errors = 0;

    window_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .sout         (sout),
        .sout_valid   (sout_valid),
        .done         (done),
        .err_underrun (err_underrun),
        .err_short    (err_short),
        .err_long     (err_long),
        .frame_count  (frame_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: tracks how far into the current window we are and
    // which byte (if any) is being sent, and derives outputs from that.
    logic             m_hold_full;
    logic [WIDTH-1:0] m_hold;
    logic [WIDTH-1:0] m_cur;
    logic             m_have;
    int               m_run;
    logic [CNT_W-1:0] m_count;
    logic             e_sout, e_valid, e_done, e_und, e_short, e_long;

    task automatic model_reset();
        m_hold_full = 1'b0;
        m_hold      = '0;
        m_cur       = '0;
        m_have      = 1'b0;
        m_run       = 0;
        m_count     = '0;
        e_sout  = 1'b0; e_valid = 1'b0; e_done = 1'b0;
        e_und   = 1'b0; e_short = 1'b0; e_long = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic dv, input logic [WIDTH-1:0] d);
        logic ready_before;
        int   prev_run;
        ready_before = !m_hold_full;
        prev_run     = m_run;
        e_sout  = 1'b0; e_valid = 1'b0; e_done = 1'b0;
        e_und   = 1'b0; e_short = 1'b0; e_long = 1'b0;
        m_run = e ? m_run + 1 : 0;
        if (e && m_run == 1) begin
            if (m_hold_full) begin
                m_cur       = m_hold;
                m_have      = 1'b1;
                m_hold_full = 1'b0;
                e_sout      = m_cur[WIDTH-1];
                e_valid     = 1'b1;
            end else begin
                e_und = 1'b1;
            end
        end else if (e && m_have) begin
            if (m_run <= WIDTH) begin
                e_sout  = m_cur[WIDTH-m_run];
                e_valid = 1'b1;
            end else begin
                e_long = 1'b1;
                m_have = 1'b0;
            end
        end else if (!e && m_have) begin
            if (prev_run == WIDTH) begin
                e_done  = 1'b1;
                m_count = m_count + 1'b1;
            end else begin
                e_short = 1'b1;
            end
            m_have = 1'b0;
        end
        if (dv && ready_before) begin
            m_hold      = d;
            m_hold_full = 1'b1;
        end
    endtask

    // Scoreboard comparison
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        check("sout",         32'(sout),         32'(e_sout));
        check("sout_valid",   32'(sout_valid),   32'(e_valid));
        check("done",         32'(done),         32'(e_done));
        check("err_underrun", 32'(err_underrun), 32'(e_und));
        check("err_short",    32'(err_short),    32'(e_short));
        check("err_long",     32'(err_long),     32'(e_long));
        check("frame_count",  32'(frame_count),  32'(m_count));
        check("din_ready",    32'(din_ready),    32'(!m_hold_full));
    endtask

    // Driver: apply inputs, take one edge, update model, sample 1 ns later.
    task automatic step(input logic e, input logic dv, input logic [WIDTH-1:0] d);
        en        = e;
        din_valid = dv;
        din       = d;
        @(posedge clk);
        model_edge(e, dv, d);
        #1;
        check_all();
    endtask

    // A window of len high cycles followed by one low cycle; optionally
    // offers byte b on window cycle load_at.
    task automatic win(input int len, input int load_at, input logic [WIDTH-1:0] b);
        for (int i = 0; i < len; i++) begin
            if (i == load_at) step(1'b1, 1'b1, b);
            else              step(1'b1, 1'b0, WIDTH'($urandom));
        end
        step(1'b0, 1'b0, WIDTH'($urandom));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Nominal frame
        step(1'b0, 1'b1, 8'hA5);
        win(8, -1, 8'h00);
        check("nominal_count", 32'(frame_count), 32'd1);

        // Back-to-back with a second byte loaded mid-shift
        step(1'b0, 1'b1, 8'h3C);
        win(8, 3, 8'hFF);
        win(8, -1, 8'h00);
        check("b2b_count", 32'(frame_count), 32'd3);

        // Underrun, then underrun with a byte offered on the rising-en edge
        win(8, -1, 8'h00);
        win(8, 0, 8'h5A);
        win(8, -1, 8'h00);

        // Short and long windows
        step(1'b0, 1'b1, 8'hF0);
        win(5, -1, 8'h00);
        step(1'b0, 1'b1, 8'h81);
        win(10, -1, 8'h00);
        check("after_errs_count", 32'(frame_count), 32'd4);

        // Reset mid-frame with a second byte held
        step(1'b0, 1'b1, 8'hC3);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h99);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b1; en = 1'b0; din_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, WIDTH'($urandom));
        win(8, -1, 8'h00);

        // Random windows: lengths 1..11, random loads and gaps
        repeat (60) begin
            int len;
            len = $urandom_range(1, 11);
            if ($urandom_range(0, 3) != 0) step(1'b0, 1'b1, WIDTH'($urandom));
            win(len, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11)) : -1,
                WIDTH'($urandom));
            repeat ($urandom_range(0, 2))
                step(1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom));
        end

        // Enough nominal frames to wrap frame_count
        repeat (256) begin
            step(1'b0, 1'b1, WIDTH'($urandom));
            win(8, -1, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
